// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared mode encodings, defaults and the rescale/saturate helper
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam logic [1:0] MODE_MAC = 2'b00;
    localparam logic [1:0] MODE_EWM = 2'b01;
    localparam logic [1:0] MODE_EWA = 2'b10;

    localparam int COL_BLOCKS_DEF = 16;

    localparam int SAT_IN_W  = 64;
    localparam int SAT_OUT_W = 32;

    // Returns {value, sat_flag}; value is sign-valid in its low 'width' bits.
    function automatic logic [SAT_OUT_W:0] sat_shift(
        input logic signed [SAT_IN_W-1:0] din,
        input int unsigned                shift,
        input int unsigned                width
    );
        logic signed [SAT_IN_W-1:0] v_sh;
        logic signed [SAT_IN_W-1:0] v_max;
        logic signed [SAT_IN_W-1:0] v_min;
        logic        [SAT_OUT_W:0]  v_ret;
        v_sh  = din >>> shift;
        v_max = (64'sd1 <<< (width - 1)) - 64'sd1;
        v_min = -(64'sd1 <<< (width - 1));
        if (v_sh > v_max) begin
            v_ret = {v_max[SAT_OUT_W-1:0], 1'b1};
        end else if (v_sh < v_min) begin
            v_ret = {v_min[SAT_OUT_W-1:0], 1'b1};
        end else begin
            v_ret = {v_sh[SAT_OUT_W-1:0], 1'b0};
        end
        return v_ret;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_row_reduce_if.sv
`default_nettype none
// ============================================================================
// Module      : tile_row_reduce_if
// Description : Tile input and reduced-vector output handshake bundle
// Revision    : 1.0 - initial release
// ============================================================================
interface tile_row_reduce_if #(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
);
    logic                                            in_valid;
    logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] in_tile;
    logic                                            out_valid;
    logic                                            out_ready;
    logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]            out_vec;
    logic [TILE_SIZE-1:0]                            out_sat;

    modport master (
        output in_valid, in_tile, out_ready,
        input  out_valid, out_vec, out_sat
    );

    modport slave (
        input  in_valid, in_tile, out_ready,
        output out_valid, out_vec, out_sat
    );
endinterface
`default_nettype wire

// File: rtl/tile_row_reduce_sync_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo2
// Description : Generic 2-deep valid/ready FIFO with a registered head entry
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo2 #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    output logic                  push_drop,
    output logic                  out_valid,
    input  wire logic             out_ready,
    output logic [WIDTH-1:0]      out_data
);
    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_pop;

    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_head;
    assign w_pop     = out_valid && out_ready;
    assign push_drop = push && (r_count == 2'd2) && !w_pop;

    // The head register keeps the last popped entry once the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (push) begin
                        r_head  <= push_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && w_pop) begin
                        r_head <= push_data;
                    end else if (push) begin
                        r_tail  <= push_data;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (push) begin
                            r_tail <= push_data;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
                default: r_count <= 2'd0;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/tile_row_reduce.sv
`default_nettype none
// ============================================================================
// Module      : tile_row_reduce
// Description : Row-reduces MAC tiles across column blocks, rescales, queues
// Revision    : 1.0 - initial release
// ============================================================================
module tile_row_reduce
    import pipeline_pkg::*;
#(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_BITS  = 8,
    parameter int COL_BLOCKS = COL_BLOCKS_DEF
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    input  wire logic [1:0]                    mode,
    tile_row_reduce_if.slave                   bus,
    output logic [$clog2(COL_BLOCKS)-1:0]      blk_cnt,
    output logic                               ovf_err
);
    localparam int c_SUM_W = ACC_WIDTH + $clog2(TILE_SIZE * COL_BLOCKS);
    localparam int c_CNT_W = $clog2(COL_BLOCKS);
    localparam int c_RES_W = TILE_SIZE * DATA_WIDTH;
    localparam int c_PAY_W = c_RES_W + TILE_SIZE;

    logic signed [c_SUM_W-1:0]              r_acc    [TILE_SIZE];
    logic        [c_CNT_W-1:0]              r_blk_cnt;
    logic                                   r_ovf;
    logic signed [c_SUM_W-1:0]              w_rowsum [TILE_SIZE];
    logic signed [c_SUM_W-1:0]              w_fin    [TILE_SIZE];
    logic        [SAT_OUT_W:0]              w_ss     [TILE_SIZE];
    logic        [TILE_SIZE-1:0][DATA_WIDTH-1:0] w_res;
    logic        [TILE_SIZE-1:0]            w_sat;
    logic        [c_PAY_W-1:0]              w_payload;
    logic        [c_PAY_W-1:0]              w_head;
    logic                                   w_last;
    logic                                   w_push;
    logic                                   w_drop;

    assign w_last = (r_blk_cnt == c_CNT_W'(COL_BLOCKS - 1));
    assign w_push = (mode == MODE_MAC) && bus.in_valid && w_last;

    always_comb begin
        for (int i = 0; i < TILE_SIZE; i++) begin
            w_rowsum[i] = '0;
            for (int j = 0; j < TILE_SIZE; j++) begin
                w_rowsum[i] = w_rowsum[i] + c_SUM_W'($signed(bus.in_tile[i][j]));
            end
            w_fin[i] = r_acc[i] + w_rowsum[i];
            w_ss[i]  = sat_shift({{(SAT_IN_W-c_SUM_W){w_fin[i][c_SUM_W-1]}}, w_fin[i]},
                                 unsigned'(FRAC_BITS), unsigned'(DATA_WIDTH));
            w_res[i] = w_ss[i][DATA_WIDTH:1];
            w_sat[i] = w_ss[i][0];
        end
    end

    assign w_payload = {w_sat, w_res};

    // Leaving MAC mode discards any partial vector, mirroring the upstream counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_cnt <= '0;
            r_ovf     <= 1'b0;
            for (int i = 0; i < TILE_SIZE; i++) r_acc[i] <= '0;
        end else begin
            if (mode != MODE_MAC || (bus.in_valid && w_last)) begin
                r_blk_cnt <= '0;
                for (int i = 0; i < TILE_SIZE; i++) r_acc[i] <= '0;
            end else if (bus.in_valid) begin
                r_blk_cnt <= r_blk_cnt + c_CNT_W'(1);
                for (int i = 0; i < TILE_SIZE; i++) r_acc[i] <= w_fin[i];
            end
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    sync_fifo2 #(
        .WIDTH (c_PAY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_payload),
        .push_drop (w_drop),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (w_head)
    );

    assign bus.out_vec = w_head[c_RES_W-1:0];
    assign bus.out_sat = w_head[c_PAY_W-1:c_RES_W];
    assign blk_cnt     = r_blk_cnt;
    assign ovf_err     = r_ovf;
endmodule
`default_nettype wire
